nrisc_run_ctrl: RTL and testbench
=================================

Name: nrisc_run_ctrl

Overview:
Boot/run sequencer for the single-cycle nRisc core and its two 8-bit memories.
- Streams a program into instruction memory and initial values into data memory from a host byte interface.
- Releases the core from reset, counts execution cycles and detects HALT (instruction 8'h00).
- Re-asserts core reset after HALT, then streams a window of data memory back to the host.
- Replaces hierarchical memory preloading and dumping in simulation and gives an FPGA-ready load/run/dump path.

Parameters:
ADDR_W, 8, address width of instruction and data memories (depth 2^ADDR_W bytes).
LEN_W, ADDR_W+1, width of length inputs (allows full-depth transfers).
MAX_CYCLES, 1024, watchdog limit in RUN cycles (used only with WATCHDOG_EN).

Ports:
CLK  in  1  clock; all state updates on posedge.
RESET  in  1  synchronous, active-low reset; sampled on posedge CLK.
start  in  1  begin a load/run/dump session; accepted only in IDLE or DONE.
inst_len  in  LEN_W  instruction bytes to load; latched on accepted start.
data_len  in  LEN_W  data bytes to load; latched on accepted start.
dump_len  in  LEN_W  data bytes to dump from address 0; latched on accepted start.
host_valid  in  1  host_data holds a byte.
host_data  in  8  load byte.
host_ready  out  1  controller accepts a byte this cycle.
imem_we  out  1  instruction memory write strobe.
imem_addr  out  ADDR_W  instruction memory write address.
imem_wdata  out  8  instruction memory write data.
dmem_we  out  1  data memory write strobe.
dmem_addr  out  ADDR_W  data memory address.
dmem_wdata  out  8  data memory write data.
dmem_rdata  in  8  data memory asynchronous read data at dmem_addr.
mem_owner  out  1  1: controller drives the memory ports; 0: core drives them (external mux select).
core_rst_n  out  1  core reset; low holds the core in reset with PC = 0.
core_instr  in  8  current core instruction (instruction memory output at the core PC).
out_valid  out  1  dump byte valid.
out_data  out  8  dump byte.
out_ready  in  1  host accepts the dump byte.
busy  out  1  state is neither IDLE nor DONE.
done  out  1  session complete; high in DONE.
timeout  out  1  RUN ended by the watchdog, not by HALT.
run_cycles  out  16  RUN-state cycles in the last session.

Behaviour:
- Reset (RESET=0 at posedge):
  - State becomes IDLE.
  - core_rst_n=0, mem_owner=1, done=0, timeout=0, run_cycles=0, counters=0.
  - All strobes and valids (host_ready, imem_we, dmem_we, out_valid) are 0.
  - Memory contents are untouched. Reset mid-session aborts it immediately.
- States: IDLE, LOAD_I, LOAD_D, RUN, DUMP, DONE.
- Accepted start (in IDLE or DONE):
  - Latches the three lengths, each saturated to 2^ADDR_W.
  - Clears the byte counter, run_cycles, timeout and done.
  - Next state: LOAD_I if inst_len>0, else LOAD_D if data_len>0, else RUN.
  - start in any other state is ignored.
- LOAD_I:
  - host_ready=1.
  - imem_we = host_valid & host_ready (combinational); imem_addr = counter; imem_wdata = host_data.
  - Counter increments per accepted byte.
  - After byte inst_len-1: counter clears; next state LOAD_D if data_len>0, else RUN.
- LOAD_D: same rules on the dmem port; after byte data_len-1, next state RUN.
- RUN:
  - mem_owner=0, core_rst_n=1, host_ready=0.
  - run_cycles increments every RUN cycle, including the HALT cycle, and saturates at 16'hFFFF.
  - core_instr==8'h00 at a RUN posedge leads to DUMP next cycle with core_rst_n=0 that same next cycle.
  - The core's HALT fetch costs exactly one RUN cycle: a program whose byte 0 is 8'h00 gives run_cycles=1.
- DUMP:
  - mem_owner=1, core_rst_n=0, dmem_we=0.
  - dmem_addr = counter; out_data = dmem_rdata (combinational); out_valid=1 while counter<dump_len.
  - Counter increments on out_valid & out_ready; out_data is held stable while out_ready=0.
  - After the last byte, or immediately if dump_len=0, next state DONE.
- DONE: done=1, core held in reset, outputs idle; waits for start.
- Address wrap: a saturated full-depth transfer ends at address 2^ADDR_W-1; the counter never wraps inside a transfer.

Optional Feature:
WATCHDOG_EN
- Defined: if run_cycles reaches MAX_CYCLES in RUN without HALT, then timeout=1 and the next state is DUMP (dump proceeds normally). timeout holds until the next accepted start or reset.
- Undefined: no watchdog; RUN ends only on HALT or reset; timeout is tied to 0.

Test Plan:
1. Reset with RESET=0 for 2 cycles, all inputs toggling -> every output at its reset value; host_ready=0; memories unchanged.
2. Program A:
   - Stimulus: start with inst_len=11, data_len=5, dump_len=5. Instructions 88,91,9D,42,A1,24,43,2C,AE,E3,00 (hex); data 05,08,FF,01,0A.
   - Response: the negate loop runs to HALT; out bytes are FB,F8,01,FF,F6; done=1; timeout=0.
3. Backpressure:
   - host_valid toggled 1/0 during load, and out_ready low for 3 cycles on dump byte 2.
   - Response: no duplicate or dropped writes; imem_addr 0..10 exactly once each; out_data stable at F8 while stalled.
4. Boundary:
   - inst_len=1 with byte 00, data_len=0, dump_len=0 -> run_cycles=1; DUMP exits immediately; done=1.
   - start pulsed during RUN -> ignored.
5. RESET pulsed low during DUMP after 2 bytes -> IDLE, core_rst_n=0, out_valid=0. A new start then completes normally.
6. With WATCHDOG_EN and MAX_CYCLES=16, program 8'hE0 branch loop without HALT -> timeout=1, run_cycles=16, DUMP performed. Without the macro, the same program runs until reset.

Source files
------------

// File: rtl/nrisc_run_ctrl_if.sv
// Bus bundle between the nRisc run controller and its host, memories and core.
// The controller connects through the slave modport; the host/system side uses master.
interface nrisc_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 1
);
    logic              start;
    logic [LEN_W-1:0]  inst_len;
    logic [LEN_W-1:0]  data_len;
    logic [LEN_W-1:0]  dump_len;
    logic              host_valid;
    logic [7:0]        host_data;
    logic              host_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [7:0]        dmem_wdata;
    logic [7:0]        dmem_rdata;
    logic              mem_owner;
    logic              core_rst_n;
    logic [7:0]        core_instr;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [15:0]       run_cycles;

    modport slave (
        input  start, inst_len, data_len, dump_len, host_valid, host_data,
               dmem_rdata, core_instr, out_ready,
        output host_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
               dmem_wdata, mem_owner, core_rst_n, out_valid, out_data, busy,
               done, timeout, run_cycles
    );

    modport master (
        output start, inst_len, data_len, dump_len, host_valid, host_data,
               dmem_rdata, core_instr, out_ready,
        input  host_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr,
               dmem_wdata, mem_owner, core_rst_n, out_valid, out_data, busy,
               done, timeout, run_cycles
    );
endinterface

// File: rtl/nrisc_run_ctrl.sv
// Load/run/dump sequencer for the nRisc core and its instruction/data memories.
// Defining WATCHDOG_EN ends RUN after MAX_CYCLES cycles without HALT and flags timeout.
module nrisc_run_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int LEN_W      = ADDR_W + 1,
    parameter int MAX_CYCLES = 1024
) (
    input logic             CLK,
    input logic             RESET,
    nrisc_run_ctrl_if.slave bus
);
    // state    | meaning
    // S_IDLE   | after reset, core in reset, waiting for start
    // S_LOAD_I | streaming host bytes into instruction memory
    // S_LOAD_D | streaming host bytes into data memory
    // S_RUN    | core released, counting cycles until HALT (or watchdog)
    // S_DUMP   | core in reset, streaming data memory window to host
    // S_DONE   | session complete, waiting for start
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_I, S_LOAD_D, S_RUN, S_DUMP, S_DONE
    } state_t;

`ifdef WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif
    localparam logic [LEN_W-1:0] DEPTH    = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    localparam logic [15:0]      WD_LIMIT = 16'(MAX_CYCLES);

    state_t           state, state_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [LEN_W-1:0] ilen, dlen, plen;
    logic [15:0]      cycles, cycles_n, cycles_inc;
    logic             timeout_q, timeout_n;
    logic             start_ok;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > DEPTH) ? DEPTH : len;
    endfunction

    assign cycles_inc = (cycles == 16'hFFFF) ? cycles : cycles + 16'd1;
    assign start_ok   = bus.start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ilen      <= '0;
            dlen      <= '0;
            plen      <= '0;
            cycles    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cycles    <= cycles_n;
            timeout_q <= timeout_n;
            if (start_ok) begin
                ilen <= sat_len(bus.inst_len);
                dlen <= sat_len(bus.data_len);
                plen <= sat_len(bus.dump_len);
            end
        end
    end

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        cycles_n       = cycles;
        timeout_n      = timeout_q;
        bus.host_ready = 1'b0;
        bus.imem_we    = 1'b0;
        bus.dmem_we    = 1'b0;
        bus.out_valid  = 1'b0;
        bus.mem_owner  = 1'b1;
        bus.core_rst_n = 1'b0;
        bus.imem_addr  = cnt[ADDR_W-1:0];
        bus.dmem_addr  = cnt[ADDR_W-1:0];
        bus.imem_wdata = bus.host_data;
        bus.dmem_wdata = bus.host_data;
        bus.out_data   = bus.dmem_rdata;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                bus.done = (state == S_DONE);
                if (start_ok) begin
                    cnt_n     = '0;
                    cycles_n  = '0;
                    timeout_n = 1'b0;
                    if (bus.inst_len != '0)      state_n = S_LOAD_I;
                    else if (bus.data_len != '0) state_n = S_LOAD_D;
                    else                         state_n = S_RUN;
                end
            end
            S_LOAD_I: begin
                bus.busy       = 1'b1;
                bus.host_ready = 1'b1;
                bus.imem_we    = bus.host_valid;
                if (bus.host_valid) begin
                    if (cnt == ilen - ONE) begin
                        cnt_n   = '0;
                        state_n = (dlen != '0) ? S_LOAD_D : S_RUN;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            S_LOAD_D: begin
                bus.busy       = 1'b1;
                bus.host_ready = 1'b1;
                bus.dmem_we    = bus.host_valid;
                if (bus.host_valid) begin
                    if (cnt == dlen - ONE) begin
                        cnt_n   = '0;
                        state_n = S_RUN;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            S_RUN: begin
                bus.busy       = 1'b1;
                bus.mem_owner  = 1'b0;
                bus.core_rst_n = 1'b1;
                cycles_n       = cycles_inc;
                if (bus.core_instr == 8'h00) begin
                    state_n = S_DUMP;
                end else if (WD_EN && cycles_inc >= WD_LIMIT) begin
                    timeout_n = 1'b1;
                    state_n   = S_DUMP;
                end
            end
            S_DUMP: begin
                bus.busy = 1'b1;
                if (cnt < plen) begin
                    bus.out_valid = 1'b1;
                    if (bus.out_ready) begin
                        cnt_n = cnt + ONE;
                        if (cnt + ONE == plen) state_n = S_DONE;
                    end
                end else begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.timeout    = timeout_q;
    assign bus.run_cycles = cycles;
endmodule

// File: tb/tb_nrisc_run_ctrl.sv
// Scoreboard bench for nrisc_run_ctrl with behavioural memories and a stand-in core.
// The stand-in core fetches straight-line from PC 0, spins on 8'hE0, and for other
// non-HALT instructions at PC<5 negates data word PC.
module tb_nrisc_run_ctrl;
    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;

    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
    typedef struct { logic [15:0] rc; logic to; } sess_t;

    logic clk, rst;
    int   n_vec = 0, n_err = 0, hs_count = 0;
    logic done_q = 1'b0;

    wr_t        exp_iw[$], exp_dw[$];
    logic [7:0] exp_bytes[$];
    sess_t      exp_sess[$];
    logic [7:0] q_inst[$], q_data[$], q_dump[$];

    logic [7:0] imem [256];
    logic [7:0] dmem [256];
    logic [7:0] pc = 8'h00;
    logic [7:0] cur;

    nrisc_run_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

    nrisc_run_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_CYCLES(16)) dut (
        .CLK(clk), .RESET(rst), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign cur            = imem[pc];
    assign bus.core_instr = imem[pc];
    assign bus.dmem_rdata = dmem[bus.dmem_addr];

    always @(posedge clk) begin
        if (bus.mem_owner) begin
            if (bus.imem_we) imem[bus.imem_addr] <= bus.imem_wdata;
            if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
        end else if (bus.core_rst_n && cur != 8'h00 && cur != 8'hE0 && pc < 8'd5) begin
            dmem[pc] <= 8'h00 - dmem[pc];
        end
        if (!bus.core_rst_n)    pc <= 8'h00;
        else if (cur != 8'hE0)  pc <= pc + 8'h01;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] val);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected event, value %0h, expected none", name, val);
    endtask

    initial begin : monitor
        wr_t   w;
        sess_t s;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.imem_we) begin
                    if (exp_iw.size() == 0) unexpected("imem_write", bus.imem_addr);
                    else begin
                        w = exp_iw.pop_front();
                        check("imem_addr", bus.imem_addr, w.addr);
                        check("imem_wdata", bus.imem_wdata, w.data);
                    end
                end
                if (bus.dmem_we) begin
                    if (exp_dw.size() == 0) unexpected("dmem_write", bus.dmem_addr);
                    else begin
                        w = exp_dw.pop_front();
                        check("dmem_addr", bus.dmem_addr, w.addr);
                        check("dmem_wdata", bus.dmem_wdata, w.data);
                    end
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_bytes.size() == 0) unexpected("dump_byte", bus.out_data);
                    else begin
                        b = exp_bytes.pop_front();
                        check("out_data", bus.out_data, b);
                    end
                    hs_count = hs_count + 1;
                end
                if (bus.done && !done_q) begin
                    if (exp_sess.size() == 0) unexpected("session_done", bus.run_cycles);
                    else begin
                        s = exp_sess.pop_front();
                        check("run_cycles", bus.run_cycles, s.rc);
                        check("timeout", bus.timeout, s.to);
                    end
                end
            end
            done_q = bus.done;
        end
    end

    task automatic send_bytes(input bit gap);
        logic [7:0] all[$];
        int n;
        all = {q_inst, q_data};
        foreach (all[i]) begin
            bus.host_valid = 1'b1;
            bus.host_data  = all[i];
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.host_ready && n < 50);
            check("host_ready_wait", bus.host_ready, 1);
            @(posedge clk); #1;
            bus.host_valid = 1'b0;
            bus.host_data  = 8'h5A;
            if (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic prepare(input int il, dl, pl, input logic [15:0] rc, input logic to,
                           input bit gap);
        sess_t s;
        foreach (q_inst[i]) exp_iw.push_back('{8'(i), q_inst[i]});
        foreach (q_data[i]) exp_dw.push_back('{8'(i), q_data[i]});
        foreach (q_dump[i]) exp_bytes.push_back(q_dump[i]);
        s.rc = rc;
        s.to = to;
        exp_sess.push_back(s);
        bus.start    = 1'b1;
        bus.inst_len = 9'(il);
        bus.data_len = 9'(dl);
        bus.dump_len = 9'(pl);
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.inst_len = 9'h155;
        bus.data_len = 9'h0AA;
        bus.dump_len = 9'h0F3;
        send_bytes(gap);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 3000) begin @(negedge clk); n++; end
        check("done_wait", bus.done, 1);
        @(negedge clk);
        check("busy_in_done", bus.busy, 0);
        check("core_rst_done", bus.core_rst_n, 0);
        check("imem_left", exp_iw.size(), 0);
        check("dmem_left", exp_dw.size(), 0);
        check("dump_left", exp_bytes.size(), 0);
        check("sess_left", exp_sess.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_ready"}, bus.host_ready, 0);
        check({tag, "_imem_we"}, bus.imem_we, 0);
        check({tag, "_dmem_we"}, bus.dmem_we, 0);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_core_rst_n"}, bus.core_rst_n, 0);
        check({tag, "_mem_owner"}, bus.mem_owner, 1);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_timeout"}, bus.timeout, 0);
        check({tag, "_run_cycles"}, bus.run_cycles, 0);
    endtask

    task automatic set_prog_a();
        q_inst = {8'h88, 8'h91, 8'h9D, 8'h42, 8'hA1, 8'h24, 8'h43, 8'h2C, 8'hAE, 8'hE3, 8'h00};
        q_data = {8'h05, 8'h08, 8'hFF, 8'h01, 8'h0A};
        q_dump = {8'hFB, 8'hF8, 8'h01, 8'hFF, 8'hF6};
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        int n;
        int base;
        rst = 1'b0;
        bus.start = 1'b0; bus.inst_len = '0; bus.data_len = '0; bus.dump_len = '0;
        bus.host_valid = 1'b0; bus.host_data = 8'h00; bus.out_ready = 1'b1;

        // reset held two cycles with inputs toggling
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            bus.start      = ~bus.start;
            bus.host_valid = ~bus.host_valid;
            bus.out_ready  = ~bus.out_ready;
            bus.host_data  = bus.host_data ^ 8'hC3;
            bus.inst_len   = 9'h1FF;
            bus.data_len   = 9'h003;
            @(negedge clk);
            check_reset_outputs("rst");
        end
        rst = 1'b1;
        bus.start = 1'b0; bus.host_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;

        // program A, continuous traffic
        set_prog_a();
        prepare(11, 5, 5, 16'd11, 1'b0, 1'b0);
        wait_done();

        // program A with load gaps and a 3-cycle stall on dump byte 2
        set_prog_a();
        base = hs_count;
        prepare(11, 5, 5, 16'd11, 1'b0, 1'b1);
        n = 0;
        while (hs_count < base + 1 && n < 500) begin @(posedge clk); #1; n++; end
        check("stall_reach", hs_count, base + 1);
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, 8'hF8);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_done();

        // single HALT instruction, empty data and dump; start during RUN ignored
        q_inst = {8'h00}; q_data.delete(); q_dump.delete();
        prepare(1, 0, 0, 16'd1, 1'b0, 1'b0);
        bus.start = 1'b1; bus.inst_len = 9'd3; bus.data_len = 9'd3; bus.dump_len = 9'd3;
        @(negedge clk);
        check("run_core_rst_n", bus.core_rst_n, 1);
        check("run_mem_owner", bus.mem_owner, 0);
        check("run_host_ready", bus.host_ready, 0);
        check("run_busy", bus.busy, 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("dump_core_rst_n", bus.core_rst_n, 0);
        check("dump_mem_owner", bus.mem_owner, 1);
        check("dump_empty_valid", bus.out_valid, 0);
        @(negedge clk);
        check("dump_empty_done", bus.done, 1);
        wait_done();

        // full-depth data load and dump with oversize lengths saturating to 256
        q_inst = {8'h00}; q_data.delete(); q_dump.delete();
        for (int i = 0; i < 256; i++) begin
            q_data.push_back(8'(i) ^ 8'hA5);
            q_dump.push_back(8'(i) ^ 8'hA5);
        end
        prepare(1, 511, 511, 16'd1, 1'b0, 1'b0);
        wait_done();

        // reset during DUMP after two bytes, then a clean session
        set_prog_a();
        base = hs_count;
        prepare(11, 5, 5, 16'd11, 1'b0, 1'b0);
        n = 0;
        while (hs_count < base + 2 && n < 500) begin @(posedge clk); #1; n++; end
        check("abort_reach", hs_count, base + 2);
        bus.out_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b1;
        bus.out_ready = 1'b1;
        exp_bytes.delete();
        exp_sess.delete();
        check("abort_dmem2", dmem[2], 8'h01);
        check("abort_dmem4", dmem[4], 8'hF6);
        @(posedge clk); #1;
        set_prog_a();
        prepare(11, 5, 5, 16'd11, 1'b0, 1'b0);
        wait_done();

        // branch-to-self program without HALT
        q_inst = {8'hE0}; q_data = {8'h11, 8'h22}; q_dump = {8'h11, 8'h22};
        prepare(1, 2, 2, 16'd16, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.inst_len = 9'd3; bus.data_len = 9'd3; bus.dump_len = 9'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
`ifdef WATCHDOG_EN
        wait_done();
        check("wd_timeout_hold", bus.timeout, 1);
        check("wd_run_cycles", bus.run_cycles, 16'd16);
`else
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("nowd_busy", bus.busy, 1);
        check("nowd_core_rst_n", bus.core_rst_n, 1);
        check("nowd_timeout", bus.timeout, 0);
        check("nowd_out_valid", bus.out_valid, 0);
        check("nowd_run_long", bus.run_cycles > 16'd16, 1);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs("nowd_rst");
        rst = 1'b1;
        exp_bytes.delete();
        exp_sess.delete();
        check("nowd_dmem_left", exp_dw.size(), 0);
`endif
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
